// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the codec-control initiator and target:
// device address, ACK/NACK levels, FSM encoding and the ACK-exit helper.
package i2c_pkg;

   localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;
   localparam logic       ACK             = 1'b0;
   localparam logic       NACK            = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_BYTE1     = 3'd3,
      ST_ACK1      = 3'd4,
      ST_BYTE2     = 3'd5,
      ST_ACK2      = 3'd6,
      ST_WAIT_STOP = 3'd7
   } state_t;

   // State that follows an ACK bit once its SCL low phase ends.
   function automatic state_t next_after_ack(input state_t s);
      case (s)
         ST_ADDR_ACK: return ST_BYTE1;
         ST_ACK1:     return ST_BYTE2;
         default:     return ST_WAIT_STOP;
      endcase
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: synchronizer, stability filter and registered rise/fall strobes.
// level, rise and fall all update on the same edge, SYNC_STAGES+FILTER_LEN clks after the pad.
module i2c_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [CW-1:0]          cnt_r;
   logic                   synced_s;

   assign synced_s = sync_r[SYNC_STAGES-1];

   // Idle bus is high, so reset to 1 to avoid a spurious edge on release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= '1;
         cnt_r  <= '0;
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], line};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (synced_s != level) begin
            if (cnt_r == CW'(FILTER_LEN - 1)) begin
               level <= synced_s;
               rise  <= synced_s;
               fall  <= ~synced_s;
               cnt_r <= '0;
            end else begin
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end else begin
            cnt_r <= '0;
         end
      end
   end

endmodule

// File: rtl/i2c_codec_target.sv
// WM8731-style I2C control-port target: accepts 3-byte writes (dev addr, 7-bit reg +
// 9-bit data), ACKs them and strobes each completed write. Never stretches SCL.
import i2c_pkg::*;

module i2c_codec_target #(
   parameter logic [6:0] DEV_ADDR    = WM8731_DEV_ADDR,
   parameter int         FILTER_LEN  = 3,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       busy,
   output logic       nack_err
);

   logic       rst_meta_r, rst_r;
   logic       scl_lvl_s, scl_rise_s, scl_fall_s;
   logic       sda_lvl_s, sda_rise_s, sda_fall_s;
   logic       start_s, stop_s;
   state_t     state_r;
   logic [2:0] cnt_r;
   logic [7:0] shift_r;
   logic       byte_done_r;
   logic [6:0] reg_addr_r;
   logic       data8_r;

   // Reset asserts immediately and releases synchronously to clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_meta_r <= 1'b1;
         rst_r      <= 1'b1;
      end else begin
         rst_meta_r <= 1'b0;
         rst_r      <= rst_meta_r;
      end
   end

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
      .clk(clk), .rst(rst_r), .line(scl_in),
      .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
   );

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
      .clk(clk), .rst(rst_r), .line(sda_in),
      .level(sda_lvl_s), .rise(sda_rise_s), .fall(sda_fall_s)
   );

   // scl level is already post-edge here, so a same-cycle SCL edge is seen first.
   assign start_s = sda_fall_s & scl_lvl_s;
   assign stop_s  = sda_rise_s & scl_lvl_s;

   // Frame FSM with bit counter, shift register and all registered outputs.
   always_ff @(posedge clk or posedge rst_r) begin
      if (rst_r) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         shift_r     <= 8'h00;
         byte_done_r <= 1'b0;
         reg_addr_r  <= 7'h00;
         data8_r     <= 1'b0;
         sda_oe      <= 1'b0;
         wr_valid    <= 1'b0;
         wr_addr     <= 7'h00;
         wr_data     <= 9'h000;
         busy        <= 1'b0;
         nack_err    <= 1'b0;
      end else begin
         wr_valid    <= 1'b0;
         nack_err    <= 1'b0;
         byte_done_r <= 1'b0;
         if (stop_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            sda_oe  <= 1'b0;
            if (state_r != ST_WAIT_STOP && state_r != ST_IDLE) begin
               nack_err <= 1'b1;
            end
         end else if (start_s) begin
            state_r <= ST_ADDR;
            busy    <= 1'b1;
            cnt_r   <= 3'd0;
            sda_oe  <= 1'b0;
            if (state_r != ST_IDLE) begin
               nack_err <= 1'b1;
            end
         end else begin
            case (state_r)
               ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                  if (byte_done_r) begin
                     case (state_r)
                        ST_ADDR: begin
                           if (shift_r[7:1] == DEV_ADDR && shift_r[0] == 1'b0) begin
                              state_r <= ST_ADDR_ACK;
                           end else begin
                              state_r  <= ST_WAIT_STOP;
                              nack_err <= 1'b1;
                           end
                        end
                        ST_BYTE1: begin
                           reg_addr_r <= shift_r[7:1];
                           data8_r    <= shift_r[0];
                           state_r    <= ST_ACK1;
                        end
                        default: begin
                           wr_addr  <= reg_addr_r;
                           wr_data  <= {data8_r, shift_r};
                           wr_valid <= 1'b1;
                           state_r  <= ST_ACK2;
                        end
                     endcase
                  end else if (scl_rise_s) begin
                     shift_r     <= {shift_r[6:0], sda_lvl_s};
                     cnt_r       <= cnt_r + 3'd1;
                     byte_done_r <= (cnt_r == 3'd7);
                  end else begin
                     cnt_r <= cnt_r;
                  end
               end
               ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                  // First SCL fall starts the ACK drive, the second releases it.
                  if (scl_fall_s) begin
                     if (!sda_oe) begin
                        sda_oe <= ~ACK;
                     end else begin
                        sda_oe  <= 1'b0;
                        cnt_r   <= 3'd0;
                        state_r <= next_after_ack(state_r);
                     end
                  end else begin
                     sda_oe <= sda_oe;
                  end
               end
               ST_IDLE, ST_WAIT_STOP: begin
                  state_r <= state_r;
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: an open-drain I2C initiator model drives
// register writes, aborts, glitches and a mid-frame reset.
import i2c_pkg::*;

module tb_i2c_codec_target;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       scl = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       busy;
   logic       nack_err;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_nack = 0;
   int q = 10;

   assign sda_line = sda_drv & ~sda_oe;

   i2c_codec_target dut (
      .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line),
      .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .nack_err(nack_err)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid) n_valid++;
      if (nack_err) n_nack++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; wt(q);
      scl = 1'b1;     wt(q);
      sda_drv = 1'b0; wt(q);
      scl = 1'b0;     wt(q);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wt(q);
      scl = 1'b1;     wt(q);
      sda_drv = 1'b1; wt(q);
   endtask

   task automatic send_bit(input logic b);
      sda_drv = b; wt(q);
      scl = 1'b1;  wt(2 * q);
      scl = 1'b0;  wt(q);
   endtask

   task automatic get_ack(output logic a);
      sda_drv = 1'b1; wt(q);
      scl = 1'b1;     wt(q);
      a = sda_line;   wt(q);
      scl = 1'b0;     wt(q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic a);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      get_ack(a);
   endtask

   task automatic write3(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2);
      logic a;
      i2c_start();
      send_byte(b0, a); chk({tag, "_ack0"}, {15'h0, a}, {15'h0, ACK});
      send_byte(b1, a); chk({tag, "_ack1"}, {15'h0, a}, {15'h0, ACK});
      send_byte(b2, a); chk({tag, "_ack2"}, {15'h0, a}, {15'h0, ACK});
      i2c_stop();
      wt(q);
   endtask

   initial begin
      int v0, n0;
      logic a;
      logic [7:0] b;

      #1 reset = 1'b1;
      wt(5);
      chk("rst_sda_oe",   {15'h0, sda_oe},   16'h0000);
      chk("rst_wr_valid", {15'h0, wr_valid}, 16'h0000);
      chk("rst_wr_addr",  {9'h0, wr_addr},   16'h0000);
      chk("rst_wr_data",  {7'h0, wr_data},   16'h0000);
      chk("rst_busy",     {15'h0, busy},     16'h0000);
      chk("rst_nack",     {15'h0, nack_err}, 16'h0000);
      reset = 1'b0;
      wt(10);

      // 1: reset register write at 100 kHz SCL (500 clk per bit)
      q = 125;
      v0 = n_valid; n0 = n_nack;
      i2c_start();
      chk("t1_busy_start", {15'h0, busy}, 16'h0001);
      send_byte(8'h34, a); chk("t1_ack0", {15'h0, a}, {15'h0, ACK});
      send_byte(8'h1E, a); chk("t1_ack1", {15'h0, a}, {15'h0, ACK});
      send_byte(8'h00, a); chk("t1_ack2", {15'h0, a}, {15'h0, ACK});
      chk("t1_busy_pre_stop", {15'h0, busy}, 16'h0001);
      i2c_stop();
      wt(q);
      chk("t1_valid", 16'(n_valid - v0), 16'h0001);
      chk("t1_addr", {9'h0, wr_addr}, 16'h000F);
      chk("t1_data", {7'h0, wr_data}, 16'h0000);
      chk("t1_busy_stop", {15'h0, busy}, 16'h0000);
      chk("t1_nack", 16'(n_nack - n0), 16'h0000);

      // 2: data bit 8 comes from byte1 bit 0
      q = 10;
      v0 = n_valid;
      write3("t2", 8'h34, 8'h0D, 8'h55);
      chk("t2_valid", 16'(n_valid - v0), 16'h0001);
      chk("t2_addr", {9'h0, wr_addr}, 16'h0006);
      chk("t2_data", {7'h0, wr_data}, 16'h0155);

      // 3: foreign address, then read request
      v0 = n_valid; n0 = n_nack;
      i2c_start();
      send_byte(8'h36, a); chk("t3_ack_36", {15'h0, a}, {15'h0, NACK});
      i2c_stop(); wt(q);
      chk("t3_nack_36", 16'(n_nack - n0), 16'h0001);
      i2c_start();
      send_byte(8'h35, a); chk("t3_ack_35", {15'h0, a}, {15'h0, NACK});
      i2c_stop(); wt(q);
      chk("t3_nack_35", 16'(n_nack - n0), 16'h0002);
      chk("t3_valid", 16'(n_valid - v0), 16'h0000);

      // 4: STOP in the middle of byte1
      v0 = n_valid; n0 = n_nack;
      i2c_start();
      send_byte(8'h34, a);
      b = 8'h1E;
      for (int i = 7; i >= 4; i--) send_bit(b[i]);
      i2c_stop(); wt(q);
      chk("t4_nack", 16'(n_nack - n0), 16'h0001);
      chk("t4_busy", {15'h0, busy}, 16'h0000);
      chk("t4_sda_oe", {15'h0, sda_oe}, 16'h0000);
      chk("t4_addr", {9'h0, wr_addr}, 16'h0006);
      chk("t4_data", {7'h0, wr_data}, 16'h0155);
      chk("t4_valid", 16'(n_valid - v0), 16'h0000);

      // 5: repeated START after ACK1, then a full write
      v0 = n_valid; n0 = n_nack;
      i2c_start();
      send_byte(8'h34, a);
      send_byte(8'h0D, a);
      i2c_start();
      chk("t5_nack_rs", 16'(n_nack - n0), 16'h0001);
      chk("t5_busy_rs", {15'h0, busy}, 16'h0001);
      send_byte(8'h34, a); chk("t5_ack0", {15'h0, a}, {15'h0, ACK});
      send_byte(8'h08, a); chk("t5_ack1", {15'h0, a}, {15'h0, ACK});
      send_byte(8'h12, a); chk("t5_ack2", {15'h0, a}, {15'h0, ACK});
      i2c_stop(); wt(q);
      chk("t5_valid", 16'(n_valid - v0), 16'h0001);
      chk("t5_addr", {9'h0, wr_addr}, 16'h0004);
      chk("t5_data", {7'h0, wr_data}, 16'h0012);

      // 6a: 1-clk glitches on SCL (low phase) and SDA (high phase) inside byte1 = 0x1E
      v0 = n_valid; n0 = n_nack;
      i2c_start();
      send_byte(8'h34, a);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      scl = 1'b1; wt(1); scl = 1'b0; wt(q);
      sda_drv = 1'b1; wt(q);
      scl = 1'b1; wt(q);
      sda_drv = 1'b0; wt(1); sda_drv = 1'b1; wt(q - 1);
      scl = 1'b0; wt(q);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      get_ack(a); chk("t6_glitch_ack1", {15'h0, a}, {15'h0, ACK});
      send_byte(8'h55, a); chk("t6_glitch_ack2", {15'h0, a}, {15'h0, ACK});
      i2c_stop(); wt(q);
      chk("t6_glitch_valid", 16'(n_valid - v0), 16'h0001);
      chk("t6_glitch_addr", {9'h0, wr_addr}, 16'h000F);
      chk("t6_glitch_data", {7'h0, wr_data}, 16'h0055);
      chk("t6_glitch_nack", 16'(n_nack - n0), 16'h0000);

      // 6b: reset while ACK1 is being driven
      i2c_start();
      send_byte(8'h34, a);
      b = 8'h0D;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_drv = 1'b1; wt(q);
      scl = 1'b1; wt(q);
      chk("t6_ack1_driven", {15'h0, sda_oe}, 16'h0001);
      reset = 1'b1;
      #1;
      chk("t6_rst_sda_oe", {15'h0, sda_oe}, 16'h0000);
      chk("t6_rst_addr", {9'h0, wr_addr}, 16'h0000);
      chk("t6_rst_data", {7'h0, wr_data}, 16'h0000);
      chk("t6_rst_busy", {15'h0, busy}, 16'h0000);
      wt(3);
      reset = 1'b0;
      wt(10);

      // 6c: clean write after the reset
      v0 = n_valid;
      write3("t6_post", 8'h34, 8'h02, 8'h9A);
      chk("t6_post_valid", 16'(n_valid - v0), 16'h0001);
      chk("t6_post_addr", {9'h0, wr_addr}, 16'h0001);
      chk("t6_post_data", {7'h0, wr_data}, 16'h009A);
      chk("t6_post_busy", {15'h0, busy}, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
